// File: rtl/rf_scan_reader_pkg.sv
// Shared types and constants for the register-file scan reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_scan_reader_pkg;

  // Default register address/data widths of the companion register file
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Scan FSM state encoding, kept as plain constants so that legacy tools
  // and waveform viewers see simple 3-bit codes
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_PRESENT = 3'd3;
  localparam state_t ST_DWELL   = 3'd4;

  // Scan mode captured when leaving IDLE
  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_AUTO = 1'b1;

  // Width of a down-counter that must hold values 0..cycles-1 (never zero)
  function automatic int dwell_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rf_scan_reader_if.sv
// Display-side handshake bundle: one (address, data) pair per transfer.
// Latency: n/a (wires only).
// Backpressure: master holds valid/addr/data stable until valid && ready.
interface rf_scan_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              disp_valid;
  logic              disp_ready;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;

  // Scan reader side: drives the pair, observes ready
  modport master (
    output disp_valid,
    output disp_addr,
    output disp_data,
    input  disp_ready
  );

  // Display sink side: consumes the pair, drives ready
  modport slave (
    input  disp_valid,
    input  disp_addr,
    input  disp_data,
    output disp_ready
  );

endinterface

// File: rtl/rf_scan_reader_dwell_timer.sv
// Loadable down-counter that times the hold between displayed registers.
// Latency: done_o is combinational from the registered count (1 cycle after load/dec).
// Backpressure: none; counts only when dec_i is asserted, saturates at zero.
module dwell_timer
  import rf_scan_reader_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CNT_W = dwell_cnt_w(DWELL_CYCLES);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: load has priority, then decrement, never wrapping below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(DWELL_CYCLES - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/rf_scan_reader.sv
// Walks RF addresses 0..NUM_REGS-1, snapshots each value and hands it to the display.
// Latency: first valid 3 edges after leaving IDLE; auto period DWELL_CYCLES+3 with ready high.
// Backpressure: PRESENT holds the captured pair indefinitely until disp_ready is seen.
module rf_scan_reader
  import rf_scan_reader_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DWELL_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              scan_en,
  input  logic              step_i,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  rf_scan_reader_if.master  disp,
  output logic              wrap_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state_d,      state_q;
  logic              mode_d,       mode_q;
  logic [ADDR_W-1:0] cur_addr_d,   cur_addr_q;
  logic              disp_valid_d, disp_valid_q;
  logic [ADDR_W-1:0] disp_addr_d,  disp_addr_q;
  logic [DATA_W-1:0] disp_data_d,  disp_data_q;
  logic              wrap_d,       wrap_q;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_done;
  logic accept;
  logic at_last;

  assign accept  = disp_valid_q && disp.disp_ready;
  assign at_last = (cur_addr_q == LAST_ADDR);

  // Hold timer between accepted pairs in auto mode
  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .done_o (tmr_done)
  );

  // Scan sequencing: issue address, capture snapshot, present, then dwell or idle
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cur_addr_d   = cur_addr_q;
    disp_valid_d = disp_valid_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    wrap_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The switch wins over a coincident step pulse
        if (scan_en) begin
          state_d = ST_ISSUE;
          mode_d  = MODE_AUTO;
        end else if (step_i) begin
          state_d = ST_ISSUE;
          mode_d  = MODE_STEP;
        end
      end

      ST_ISSUE: begin
        // rd_addr already stable; one cycle of margin for the RF read path
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // Snapshot: later RF writes must not disturb the presented pair
        disp_data_d  = rd_data;
        disp_addr_d  = cur_addr_q;
        disp_valid_d = 1'b1;
        state_d      = ST_PRESENT;
      end

      ST_PRESENT: begin
        // Valid is never withdrawn; leaving scan mode takes effect after accept
        if (accept) begin
          disp_valid_d = 1'b0;
          cur_addr_d   = at_last ? '0 : cur_addr_q + 1'b1;
          wrap_d       = at_last;
          if ((mode_q == MODE_AUTO) && scan_en) begin
            state_d  = ST_DWELL;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DWELL: begin
        // Dropping the switch abandons the hold but keeps the scan position
        if (!scan_en) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_ISSUE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        disp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any handshake in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_STEP;
      cur_addr_q   <= '0;
      disp_valid_q <= 1'b0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cur_addr_q   <= cur_addr_d;
      disp_valid_q <= disp_valid_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      wrap_q       <= wrap_d;
    end
  end

  // rd_addr is the scan position register itself, so it is glitch-free
  assign rd_addr         = cur_addr_q;
  assign disp.disp_valid = disp_valid_q;
  assign disp.disp_addr  = disp_addr_q;
  assign disp.disp_data  = disp_data_q;
  // wrap_o is high for the one cycle following the accept of the last register
  assign wrap_o          = wrap_q;

endmodule

// File: tb/tb_rf_scan_reader.sv
// Directed bench for rf_scan_reader with a scoreboard-driven display monitor.
// Latency: checks first-valid edge count and the DWELL+3 auto-scan period.
// Backpressure: stalls the display sink while a register is presented.
module tb_rf_scan_reader;

  localparam int NR     = 32;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int DWELL  = 4;
  localparam int PERIOD = DWELL + 3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } pair_t;

  logic          clk     = 1'b0;
  logic          rstn    = 1'b0;
  logic          scan_en = 1'b0;
  logic          step_i  = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wrap_o;

  logic [DW-1:0] rf [NR];

  int    n_chk        = 0;
  int    n_pass       = 0;
  int    n_acc        = 0;
  int    wrap_cnt     = 0;
  int    cyc          = 0;
  bit    exp_wrap_nxt = 1'b0;
  int    acc_t[$];
  pair_t sb_q[$];

  rf_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

  rf_scan_reader #(
    .NUM_REGS     (NR),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .scan_en (scan_en),
    .step_i  (step_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .disp    (dif),
    .wrap_o  (wrap_o)
  );

  // Combinational register-file read port model
  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic push(input int a, input logic [DW-1:0] d);
    pair_t p;
    p.a = AW'(a);
    p.d = d;
    sb_q.push_back(p);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int n, input int bound);
    int k;
    k = 0;
    while (n_acc < n && k < bound) begin
      tick();
      k++;
    end
    check("accept_wait", 64'(n_acc >= n), 64'd1);
  endtask

  task automatic do_step(input int exp_addr);
    int lat;
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    lat = 1;
    while (!dif.disp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("step_latency", 64'(lat), 64'd3);
    check("step_addr", 64'(dif.disp_addr), 64'(exp_addr));
  endtask

  // Monitor: pops the scoreboard on every accepted pair, tracks wrap pulses
  always @(negedge clk) begin
    pair_t p;
    if (rstn) begin
      if (exp_wrap_nxt) begin
        check("wrap_pulse", 64'(wrap_o), 64'd1);
        exp_wrap_nxt = 1'b0;
      end
      if (wrap_o) wrap_cnt = wrap_cnt + 1;
      if (dif.disp_valid && dif.disp_ready) begin
        acc_t.push_back(cyc);
        n_acc = n_acc + 1;
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          p = sb_q.pop_front();
          check("sb_addr", 64'(dif.disp_addr), 64'(p.a));
          check("sb_data", 64'(dif.disp_data), 64'(p.d));
        end
        if (dif.disp_addr == AW'(NR - 1)) exp_wrap_nxt = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) rf[i] = DW'(i);
    dif.disp_ready = 1'b1;
    tick(2);

    // Reset state
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_valid", 64'(dif.disp_valid), 64'd0);
    check("rst_disp_addr", 64'(dif.disp_addr), 64'd0);
    check("rst_disp_data", 64'(dif.disp_data), 64'd0);
    check("rst_wrap", 64'(wrap_o), 64'd0);

    // Auto scan over the whole file, reg 5 rewritten beforehand, then wrap to 0
    rf[5] = 32'hDEADBEEF;
    for (int i = 0; i < NR; i++) push(i, (i == 5) ? 32'hDEADBEEF : DW'(i));
    push(0, 32'h0);
    scan_en = 1'b1;
    rstn    = 1'b1;
    tick();
    check("first_valid_e1", 64'(dif.disp_valid), 64'd0);
    tick();
    check("first_valid_e2", 64'(dif.disp_valid), 64'd0);
    tick();
    check("first_valid_e3", 64'(dif.disp_valid), 64'd1);
    check("first_addr", 64'(dif.disp_addr), 64'd0);

    wait_acc(3, 4 * PERIOD);
    if (acc_t.size() >= 3) begin
      check("period_0_1", 64'(acc_t[1] - acc_t[0]), 64'(PERIOD));
      check("period_1_2", 64'(acc_t[2] - acc_t[1]), 64'(PERIOD));
    end

    // Backpressure while register 3 is presented; RF write must not leak in
    dif.disp_ready = 1'b0;
    for (int k = 0; k < 20 && !dif.disp_valid; k++) tick();
    check("bp_valid_seen", 64'(dif.disp_valid), 64'd1);
    check("bp_addr_seen", 64'(dif.disp_addr), 64'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) rf[3] = 32'h55;
      check("bp_valid", 64'(dif.disp_valid), 64'd1);
      check("bp_addr", 64'(dif.disp_addr), 64'd3);
      check("bp_data", 64'(dif.disp_data), 64'd3);
    end
    dif.disp_ready = 1'b1;

    wait_acc(33, 40 * PERIOD);
    check("wrap_count", 64'(wrap_cnt), 64'd1);

    // Second lap up to register 7, then reset in the middle of the dwell
    push(1, 32'h1);
    push(2, 32'h2);
    push(3, 32'h55);
    push(4, 32'h4);
    push(5, 32'hDEADBEEF);
    push(6, 32'h6);
    push(7, 32'h7);
    wait_acc(40, 10 * PERIOD);
    tick(2);
    check("pre_rst_rd_addr", 64'(rd_addr), 64'd8);
    check("pre_rst_disp_addr", 64'(dif.disp_addr), 64'd7);
    check("pre_rst_disp_data", 64'(dif.disp_data), 64'd7);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_rd_addr", 64'(rd_addr), 64'd0);
    check("async_rst_valid", 64'(dif.disp_valid), 64'd0);
    check("async_rst_disp_addr", 64'(dif.disp_addr), 64'd0);
    check("async_rst_disp_data", 64'(dif.disp_data), 64'd0);
    tick(2);
    push(0, 32'h0);
    rstn = 1'b1;
    wait_acc(41, 2 * PERIOD);

    // Leaving auto mode during the dwell: back to idle, position kept
    scan_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("dwell_exit_valid", 64'(dif.disp_valid), 64'd0);
    end
    check("dwell_exit_rd_addr", 64'(rd_addr), 64'd1);

    // Step mode from a fresh reset
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(3);
    check("step_idle_valid", 64'(dif.disp_valid), 64'd0);

    push(0, 32'h0);
    do_step(0);
    tick();
    push(1, 32'h1);
    dif.disp_ready = 1'b0;
    do_step(1);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    tick();
    check("step_hold_valid", 64'(dif.disp_valid), 64'd1);
    check("step_hold_addr", 64'(dif.disp_addr), 64'd1);
    dif.disp_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("step_ignored_valid", 64'(dif.disp_valid), 64'd0);
    end
    check("step_rd_addr", 64'(rd_addr), 64'd2);
    push(2, 32'h2);
    do_step(2);
    tick();
    wait_acc(44, 5);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_scan_reader.md
Name: rf_scan_reader

Overview:
- Read-side companion to the register file. It walks register addresses 0..NUM_REGS-1 through one RF combinational read port and captures each value.
- Each captured (address, data) pair is handed to the seven-segment/display path over a valid/ready handshake.
- Between pairs it holds for a programmable dwell time, so a human can read each register value on the board.

Parameters:
- NUM_REGS, 32, number of registers scanned; power of two.
- ADDR_W, 5, register address width; equals log2(NUM_REGS).
- DATA_W, 32, register data width.
- DWELL_CYCLES, 25000000, clock cycles to hold after each accepted pair. Minimum 1. Simulation uses 4.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- scan_en  in  1  level. 1 = continuous auto-scan. Driven from a board switch.
- step_i  in  1  single-cycle pulse. Performs one read/present/advance while scan_en=0.
- rd_addr  out  ADDR_W  address to the RF read port (A1 or A2).
- rd_data  in  DATA_W  RF read data, combinational from rd_addr.
- disp_valid  out  1  disp_addr/disp_data are valid.
- disp_ready  in  1  display sink accepts the pair.
- disp_addr  out  ADDR_W  address of the presented register.
- disp_data  out  DATA_W  captured register value.
- wrap_o  out  1  one-cycle pulse when the address wraps from NUM_REGS-1 to 0.

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE.
  - cur_addr = 0, rd_addr = 0.
  - disp_valid = 0, disp_addr = 0, disp_data = 0.
  - wrap_o = 0, dwell counter = 0.
  - Reset asserted mid-operation aborts immediately. No partial handshake survives.
- rd_addr is a register and always equals cur_addr.
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, DWELL.
- IDLE:
  - If scan_en=1, go to ISSUE and set mode=auto.
  - Else if step_i=1, go to ISSUE and set mode=step.
  - scan_en has priority over step_i.
- ISSUE: rd_addr is stable. Wait one cycle to cover RF read settling, then go to CAPTURE.
- CAPTURE:
  - Latch disp_data <= rd_data and disp_addr <= cur_addr.
  - Set disp_valid <= 1 and go to PRESENT.
- PRESENT:
  - Hold disp_valid=1. disp_addr/disp_data are stable until accepted.
  - On disp_valid && disp_ready:
    - Clear disp_valid next cycle.
    - Advance cur_addr, modulo NUM_REGS.
    - If the old cur_addr = NUM_REGS-1, pulse wrap_o for that one cycle.
  - Then go to:
    - DWELL, if mode=auto and scan_en=1;
    - IDLE, if mode=step or scan_en=0.
  - scan_en dropping while in PRESENT does not withdraw valid. The handshake completes first.
- DWELL:
  - Counter loads DWELL_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to ISSUE.
  - If scan_en=0 during DWELL, go to IDLE next cycle. cur_addr is retained.
- step_i outside IDLE is ignored, as is step_i while scan_en=1.
- The pair is a snapshot taken in CAPTURE. RF writes after CAPTURE do not alter disp_data.
- Auto-scan period with disp_ready held 1: ISSUE 1 + CAPTURE 1 + PRESENT 1 + DWELL DWELL_CYCLES = DWELL_CYCLES+3 cycles per register.
- First disp_valid after reset release with scan_en=1: 3rd rising edge (IDLE->ISSUE, ISSUE->CAPTURE, CAPTURE->PRESENT).
- Register 0 is presented with whatever the RF returns. The reader does no special-casing.

Decomposition:
- Shared package: state enum (IDLE, ISSUE, CAPTURE, PRESENT, DWELL) and the ADDR_W/DATA_W defaults.
- One sub-module: dwell_timer. It is a loadable down-counter with width $clog2(DWELL_CYCLES) and outputs done when the count is 0.
- Everything else stays in the top module.

Test Plan:
- Reset RF (rf[i]=i), DWELL_CYCLES=4, scan_en=1, disp_ready=1 -> pairs (0,0x0),(1,0x1),(2,0x2) accepted exactly 7 cycles apart. First valid is on the 3rd edge after reset release.
- Full scan to the end -> pair (31,0x1F) is accepted, wrap_o pulses for exactly 1 cycle on that accept, and the next pair is (0,0x0).
- Backpressure: hold disp_ready=0 for 10 cycles while presenting addr 3 -> disp_valid stays 1, disp_addr=3, disp_data=0x3 unchanged. An RF write of 0x55 to reg 3 during the stall does not change disp_data. Accept on ready=1.
- Step mode: scan_en=0, pulse step_i three times with ready=1 -> pairs (0,0),(1,1),(2,2), each followed by a return to IDLE with no dwell. A step_i pulse during PRESENT is ignored.
- RF write 0xDEADBEEF to reg 5 before the scan reaches 5 -> pair (5,0xDEADBEEF).
- Assert rstn=0 mid-DWELL at addr 7 -> disp_valid=0 and rd_addr=0 immediately, without waiting for a clock edge. The scan restarts at (0,0x0).
